// File: rtl/branch_fetch_unit.sv
// Branch/fetch unit: holds the fetch PC, the registered {N,Z,V,C} flags and a
// retired-instruction counter, and resolves B, B.LT and CBZ redirects.
//
// Handshake: there is no valid/ready pair on this block. An instruction advances
// the PC, flags and retired counter only on an edge where instr_valid=1 and
// stall=0. The upstream logic must hold its inputs stable while stall is high.
module branch_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        brtaken,
   input  logic        uncondbr,
   input  logic        isltnotcbz,
   input  logic        setflag,
   input  logic        alu_neg,
   input  logic        alu_zero,
   input  logic        alu_ovf,
   input  logic        alu_carry,
   input  logic        rt_zero,
   input  logic [18:0] cond_addr19,
   input  logic [25:0] br_addr26,
   output logic [63:0] pc,
   output logic [3:0]  flags,
   output logic        redirect,
   output logic        instr_valid,
   output logic [31:0] retired
);

   // BOOT covers the single bubble cycle after reset; RUN is steady state.
   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [3:0]  flags_q, flags_d;
   logic [31:0] retired_q, retired_d;

   logic [63:0] offset_ext;
   logic [63:0] target;
   logic        taken;
   logic        run;
   logic        advance;

   assign run     = (state_q == RUN);
   assign advance = run && !stall;

   // Select and sign-extend the word offset, then form the byte target.
   always_comb begin
      offset_ext = 64'h0;
      if (uncondbr) begin
         offset_ext = {{38{br_addr26[25]}}, br_addr26};
      end else begin
         offset_ext = {{45{cond_addr19[18]}}, cond_addr19};
      end
      target = pc_q + {offset_ext[61:0], 2'b00};
   end

   // Branch decision; B.LT uses the flags registered before this edge, and
   // inputs irrelevant to the decoded class are never looked at.
   always_comb begin
      taken = 1'b0;
      if (brtaken) begin
         if (uncondbr) begin
            taken = 1'b1;
         end else if (isltnotcbz) begin
            taken = flags_q[3] ^ flags_q[1];
         end else begin
            taken = rt_zero;
         end
      end
   end

   // Next-state values for the architectural registers.
   always_comb begin
      pc_d      = pc_q;
      flags_d   = flags_q;
      retired_d = retired_q;
      state_d   = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = BOOT;
      endcase
      if (advance) begin
         pc_d      = taken ? target : (pc_q + 64'd4);
         retired_d = retired_q + 32'd1;
         if (setflag) begin
            flags_d = {alu_neg, alu_zero, alu_ovf, alu_carry};
         end
      end
   end

   // State register with synchronous reset taking priority over any redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         flags_q   <= 4'b0000;
         retired_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         flags_q   <= flags_d;
         retired_q <= retired_d;
      end
   end

   assign pc          = pc_q;
   assign flags       = flags_q;
   assign retired     = retired_q;
   assign instr_valid = run;
   assign redirect    = taken && run && !stall;

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Self-checking bench for branch_fetch_unit: directed scenarios plus a
// randomized run, all compared against a behavioural model kept here.
module tb_branch_fetch_unit;

   localparam logic [63:0] RST_PC = 64'h0;

   // ---------------- clock / reset block ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall, brtaken, uncondbr, isltnotcbz, setflag;
   logic        alu_neg, alu_zero, alu_ovf, alu_carry, rt_zero;
   logic [18:0] cond_addr19;
   logic [25:0] br_addr26;
   logic [63:0] pc;
   logic [3:0]  flags;
   logic        redirect, instr_valid;
   logic [31:0] retired;

   branch_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .stall(stall), .brtaken(brtaken),
      .uncondbr(uncondbr), .isltnotcbz(isltnotcbz), .setflag(setflag),
      .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
      .alu_carry(alu_carry), .rt_zero(rt_zero), .cond_addr19(cond_addr19),
      .br_addr26(br_addr26), .pc(pc), .flags(flags), .redirect(redirect),
      .instr_valid(instr_valid), .retired(retired)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- behavioural reference model ----------------
   logic [63:0] m_pc;
   bit          m_n, m_z, m_v, m_c;
   logic [31:0] m_ret;
   bit          m_valid;

   function automatic longint m_offset_bytes();
      longint off;
      if (uncondbr) begin
         off = longint'(br_addr26);
         if (br_addr26[25]) off = off - (longint'(1) << 26);
      end else begin
         off = longint'(cond_addr19);
         if (cond_addr19[18]) off = off - (longint'(1) << 19);
      end
      return off * 4;
   endfunction

   function automatic bit m_taken();
      if (!brtaken) return 1'b0;
      if (uncondbr) return 1'b1;
      if (isltnotcbz) return (m_n != m_v);
      return rt_zero;
   endfunction

   function automatic bit m_redirect();
      return m_taken() && m_valid && !stall;
   endfunction

   function automatic logic [3:0] m_flags();
      return {m_n, m_z, m_v, m_c};
   endfunction

   // Apply the edge rules to the model, then let the DUT take the same edge.
   task automatic advance();
      if (reset) begin
         m_pc = RST_PC; m_n = 0; m_z = 0; m_v = 0; m_c = 0;
         m_ret = 0; m_valid = 0;
      end else begin
         if (m_valid && !stall) begin
            if (m_taken()) m_pc = m_pc + 64'(m_offset_bytes());
            else           m_pc = m_pc + 64'd4;
            if (setflag) begin
               m_n = alu_neg; m_z = alu_zero; m_v = alu_ovf; m_c = alu_carry;
            end
            m_ret = m_ret + 32'd1;
         end
         m_valid = 1;
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      reset = 0; stall = 0; brtaken = 0; uncondbr = 0; isltnotcbz = 0;
      setflag = 0; alu_neg = 0; alu_zero = 0; alu_ovf = 0; alu_carry = 0;
      rt_zero = 0; cond_addr19 = '0; br_addr26 = '0;
   endtask

   // Unconditional branch from the current PC to an absolute address.
   task automatic goto_pc(input logic [63:0] dest);
      logic [63:0] diff;
      set_idle();
      diff = dest - m_pc;
      brtaken = 1; uncondbr = 1; br_addr26 = diff[27:2];
      advance();
      set_idle();
   endtask

   task automatic set_flags_via(input logic [3:0] nzvc);
      set_idle();
      setflag = 1;
      {alu_neg, alu_zero, alu_ovf, alu_carry} = nzvc;
      advance();
      set_idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_idle(); reset = 1;
      advance();
      checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc); end
      checks++; if (flags !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags); end
      checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      set_idle(); brtaken = 1; uncondbr = 1; br_addr26 = 26'd5;
      #1;
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL boot_redirect got=%b exp=0", redirect); end
      advance();
      checks++; if (pc !== 64'h0) begin errors++; $display("FAIL boot_pc got=%h exp=0", pc); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL run_valid got=%b exp=1", instr_valid); end
      set_idle();
      advance();
      checks++; if (pc !== 64'h4) begin errors++; $display("FAIL seq_pc1 got=%h exp=4", pc); end
      advance();
      checks++; if (pc !== 64'h8) begin errors++; $display("FAIL seq_pc2 got=%h exp=8", pc); end
      checks++; if (retired !== 32'd2) begin errors++; $display("FAIL seq_retired got=%0d exp=2", retired); end
   endtask

   task automatic test_uncond();
      goto_pc(64'h40);
      checks++; if (pc !== 64'h40) begin errors++; $display("FAIL goto_pc got=%h exp=40", pc); end
      brtaken = 1; uncondbr = 1; br_addr26 = 26'h3FFFFFE;
      isltnotcbz = 1'($urandom); rt_zero = 1'($urandom);
      #1;
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL b_redirect got=%b exp=1", redirect); end
      advance();
      checks++; if (pc !== 64'h38) begin errors++; $display("FAIL b_back_pc got=%h exp=38", pc); end
      set_idle();
   endtask

   task automatic test_blt();
      goto_pc(64'h0C);
      set_flags_via(4'b1000);
      checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL blt_flags got=%b exp=1000", flags); end
      brtaken = 1; isltnotcbz = 1; cond_addr19 = 19'd3;
      #1;
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL blt_taken_redir got=%b exp=1", redirect); end
      advance();
      checks++; if (pc !== 64'h1C) begin errors++; $display("FAIL blt_taken_pc got=%h exp=1c", pc); end
      goto_pc(64'h0C);
      set_flags_via(4'b1010);
      brtaken = 1; isltnotcbz = 1; cond_addr19 = 19'd3;
      #1;
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL blt_not_redir got=%b exp=0", redirect); end
      advance();
      checks++; if (pc !== 64'h14) begin errors++; $display("FAIL blt_not_pc got=%h exp=14", pc); end
      // Flags N=V=1 now; a same-instruction setflag must not change this decision.
      set_idle(); brtaken = 1; isltnotcbz = 1; cond_addr19 = 19'd3;
      setflag = 1; alu_neg = 1; alu_ovf = 0;
      advance();
      checks++; if (pc !== 64'h18) begin errors++; $display("FAIL blt_same_setflag_pc got=%h exp=18", pc); end
      checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL blt_same_setflag_flags got=%b exp=1000", flags); end
      set_idle();
   endtask

   task automatic test_cbz();
      goto_pc(64'h20);
      brtaken = 1; rt_zero = 1; cond_addr19 = 19'd5;
      advance();
      checks++; if (pc !== 64'h34) begin errors++; $display("FAIL cbz_taken_pc got=%h exp=34", pc); end
      goto_pc(64'h20);
      brtaken = 1; rt_zero = 0; cond_addr19 = 19'd5;
      advance();
      checks++; if (pc !== 64'h24) begin errors++; $display("FAIL cbz_not_pc got=%h exp=24", pc); end
      set_idle();
   endtask

   task automatic test_stall();
      logic [31:0] ret0;
      goto_pc(64'h100);
      set_flags_via(4'b0101);
      ret0 = m_ret;
      brtaken = 1; uncondbr = 1; br_addr26 = 26'd8;
      setflag = 1; {alu_neg, alu_zero, alu_ovf, alu_carry} = 4'b1010;
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL stall_redir%0d got=%b exp=0", i, redirect); end
         advance();
         checks++; if (pc !== 64'h104) begin errors++; $display("FAIL stall_pc%0d got=%h exp=104", i, pc); end
         checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL stall_flags%0d got=%b exp=0101", i, flags); end
         checks++; if (retired !== ret0) begin errors++; $display("FAIL stall_ret%0d got=%0d exp=%0d", i, retired, ret0); end
      end
      stall = 0;
      #1;
      checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL unstall_redir got=%b exp=1", redirect); end
      advance();
      checks++; if (pc !== 64'h124) begin errors++; $display("FAIL unstall_pc got=%h exp=124", pc); end
      checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL unstall_flags got=%b exp=1010", flags); end
      set_idle();
      advance();
      checks++; if (pc !== 64'h128) begin errors++; $display("FAIL after_branch_pc got=%h exp=128", pc); end
      // Offset zero: a taken branch to itself holds the PC but still retires.
      ret0 = m_ret;
      brtaken = 1; uncondbr = 1; br_addr26 = 26'd0;
      advance();
      checks++; if (pc !== 64'h128) begin errors++; $display("FAIL self_branch_pc got=%h exp=128", pc); end
      checks++; if (retired !== ret0 + 32'd1) begin errors++; $display("FAIL self_branch_ret got=%0d exp=%0d", retired, ret0 + 32'd1); end
      set_idle();
   endtask

   task automatic test_wrap_and_reset();
      logic [63:0] pc0;
      force dut.retired_q = 32'hFFFFFFFE;
      #1;
      release dut.retired_q;
      m_ret = 32'hFFFFFFFE;
      pc0 = m_pc;
      set_idle();
      advance();
      checks++; if (retired !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffffffff", retired); end
      advance();
      checks++; if (retired !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", retired); end
      checks++; if (pc !== pc0 + 64'd8) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, pc0 + 64'd8); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", instr_valid); end
      brtaken = 1; uncondbr = 1; br_addr26 = 26'd100; reset = 1;
      advance();
      checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_mid_branch_pc got=%h exp=%h", pc, RST_PC); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_branch_valid got=%b exp=0", instr_valid); end
      reset = 0;
      #1;
      checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL post_reset_redir got=%b exp=0", redirect); end
      advance();
      set_idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         stall = ($urandom_range(0, 3) == 0);
         brtaken = 1'($urandom); uncondbr = 1'($urandom); isltnotcbz = 1'($urandom);
         setflag = 1'($urandom); rt_zero = 1'($urandom);
         {alu_neg, alu_zero, alu_ovf, alu_carry} = 4'($urandom);
         cond_addr19 = 19'($urandom); br_addr26 = 26'($urandom);
         #1;
         checks++; if (redirect !== m_redirect()) begin errors++; $display("FAIL rnd_redir[%0d] got=%b exp=%b", i, redirect, m_redirect()); end
         advance();
         checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
         checks++; if (flags !== m_flags()) begin errors++; $display("FAIL rnd_flags[%0d] got=%b exp=%b", i, flags, m_flags()); end
         checks++; if (retired !== m_ret) begin errors++; $display("FAIL rnd_ret[%0d] got=%0d exp=%0d", i, retired, m_ret); end
         checks++; if (instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, instr_valid, m_valid); end
      end
      set_idle();
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      m_pc = RST_PC; m_n = 0; m_z = 0; m_v = 0; m_c = 0; m_ret = 0; m_valid = 0;
      set_idle();
      @(negedge clk);
      test_reset();
      test_uncond();
      test_blt();
      test_cbz();
      test_stall();
      test_wrap_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_fetch_unit.md
BRANCH_FETCH_UNIT -- requirements
Module: branch_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, which holds the PC and flags when high.
REQ-005 SHALL have port brtaken, input, 1, meaning the current instruction is a branch candidate (B, B.LT, CBZ).
REQ-006 SHALL have port uncondbr, input, 1, which selects the 26-bit offset and an unconditional branch when high.
REQ-007 SHALL have port isltnotcbz, input, 1, which selects the B.LT condition (1) or the CBZ condition (0).
REQ-008 SHALL have port setflag, input, 1, which latches the ALU flags at the end of the cycle.
REQ-009 SHALL have ports alu_neg, alu_zero, alu_ovf, alu_carry, input, 1 each, the ALU flags of the current instruction.
REQ-010 SHALL have port rt_zero, input, 1, meaning the CBZ test register reads zero.
REQ-011 SHALL have port cond_addr19, input, 19, the signed word offset for B.LT/CBZ.
REQ-012 SHALL have port br_addr26, input, 26, the signed word offset for B.
REQ-013 SHALL have port pc, output, 64, the address of the instruction currently fetched.
REQ-014 SHALL have port flags, output, 4, the registered {N,Z,V,C} flags.
REQ-015 SHALL have port redirect, output, 1, a combinational flag that is high when the next PC is the branch target.
REQ-016 SHALL have port instr_valid, output, 1, which is low in the first cycle after reset and high afterwards.
REQ-017 SHALL have port retired, output, 32, the count of non-stalled valid cycles.

Function
REQ-018 SHALL form the branch target as pc + (sign-extended offset << 2), using 64-bit modulo arithmetic.
REQ-019 SHALL sign-extend br_addr26 when uncondbr=1, and cond_addr19 otherwise.
REQ-020 SHALL compute taken as follows:
- brtaken=0: taken=0.
- brtaken=1 and uncondbr=1: taken=1.
- brtaken=1, uncondbr=0, isltnotcbz=1: taken = registered N XOR registered V.
- brtaken=1, uncondbr=0, isltnotcbz=0: taken = rt_zero.
REQ-021 SHALL drive redirect = taken AND instr_valid AND NOT stall.
REQ-022 SHALL set the next PC as follows when stall=0 and instr_valid=1: target if taken, else pc+4.
REQ-023 SHALL hold pc unchanged when stall=1 or instr_valid=0.
REQ-024 SHALL evaluate B.LT against the flags registered before the current edge; a setflag on the same instruction SHALL NOT affect that branch decision.
REQ-025 SHALL load {alu_neg, alu_zero, alu_ovf, alu_carry} into flags on the edge when setflag=1, stall=0 and instr_valid=1; otherwise flags SHALL hold.
REQ-026 SHALL increment retired by 1 each edge with stall=0 and instr_valid=1, wrapping from 32'hFFFFFFFF to 0.
REQ-027 SHALL implement an instr_valid state machine:
- States BOOT and RUN.
- BOOT -> RUN unconditionally on the next edge.
- RUN stays in RUN until reset.
- instr_valid = (state==RUN).
REQ-028 SHALL treat the case where the target equals pc (offset 0) as a normal taken branch, so pc holds its value.
REQ-029 SHALL treat X on ports that are don't-care for the decoded class as ignored; for example, isltnotcbz SHALL be ignored when uncondbr=1.

Reset
REQ-030 SHALL, on the edge where reset=1, set pc=RESET_PC, flags=4'b0000, retired=0 and state=BOOT, regardless of stall.
REQ-031 SHALL apply reset asserted mid-branch with priority over the redirect, so pc=RESET_PC on that edge.
REQ-032 SHALL hold redirect=0 and instr_valid=0 in the first cycle after reset deasserts.

Verification
REQ-033 Reset then 3 non-branch cycles SHALL give pc = 0 -> 0 (BOOT) -> 4 -> 8, and retired=2.
REQ-034 At pc=0x40, brtaken=1, uncondbr=1, br_addr26=26'h3FFFFFE (-2) SHALL give next pc=0x38 and redirect=1.
REQ-035 An instruction with setflag=1, alu_neg=1, alu_ovf=0, followed by B.LT with cond_addr19=3 at pc=0x10, SHALL give pc=0x1C; the same sequence with alu_ovf=1 SHALL give pc=0x14.
REQ-036 CBZ at pc=0x20 with cond_addr19=5 SHALL give pc=0x34 when rt_zero=1 and pc=0x24 when rt_zero=0.
REQ-037 Stall high for 2 cycles during a taken B SHALL hold pc, flags and retired, and keep redirect=0; after stall drops, the branch SHALL resolve once.
REQ-038 retired preloaded near 32'hFFFFFFFF SHALL wrap to 0 with no other side effect, and reset asserted during a taken branch SHALL give pc=RESET_PC.
